fmadd_mul_pn_pipe: RTL and testbench
====================================

FMADD_MUL_PN_PIPE -- requirements
Module: fmadd_mul_pn_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field bits.
REQ-002 Parameter MAN_W, default 7, fraction bits (bfloat16); product width P = 2*MAN_W+2.
REQ-003 Parameter BIAS, default 127, exponent bias.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_l  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream holds a product.
REQ-007 in_ready  output  1  block accepts a product this cycle.
REQ-008 in_sign  input  1  product sign.
REQ-009 in_exp_db  input  EXP_W+1  double-biased exponent sum (subnormal operands counted as 1).
REQ-010 in_prod  input  P  raw mantissa product, format xx.f (two integer bits).
REQ-011 out_valid  output  1  result held.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_no  output  1+EXP_W+1+P  {sign, exponent, normalized mantissa}.
REQ-014 out_sticky  output  1  shifted-out bits nonzero.
REQ-015 out_ovf  output  1  biased exponent >= 2^EXP_W-1.

Function
REQ-016 Transfer on in_valid&in_ready at input and on out_valid&out_ready at output.
REQ-017 Two register stages, S1 (LZC + exponent arithmetic) and S2 (shift + pack); latency exactly 2 cycles with out_ready high; one result per cycle sustained.
REQ-018 in_ready = !S1_valid | S1 advancing; S1 advances when !S2_valid | out_ready; no combinational path from in_valid to out_valid.
REQ-019 L = leading-zero count of in_prod (0..P); E = in_exp_db - BIAS + 1 - L, computed signed in EXP_W+3 bits, never truncated before comparison.
REQ-020 E >= 1: exponent = E, mantissa = in_prod << L (bit P-1 set).
REQ-021 E <= 0: mantissa = (in_prod << L) >> (1-E), shift clamped to P; exponent = 0.
REQ-022 in_prod == 0: exponent 0, mantissa 0, sticky 0, ovf 0, regardless of in_exp_db.
REQ-023 out_ovf = 1 iff E >= 2^EXP_W-1; data still packed per REQ-020.
REQ-024 Sign passes through unchanged.
REQ-025 Stalled stage holds its data stable; order preserved; no drop or duplication.
REQ-026 Simultaneous accept and release in the same cycle is legal at every stage.

Reset
REQ-027 rst_l low: S1_valid, S2_valid, out_valid = 0; all data registers and out_no, out_sticky, out_ovf = 0; in_ready = 1 after reset.
REQ-028 Reset mid-flight discards every in-flight product; no output after release until new inputs.

Configuration
REQ-029 Macro FMADD_PN_PIPE_EXACT_STICKY_EN defined: out_sticky = OR of every bit lost in the REQ-021 right shift.
REQ-030 Macro undefined: out_sticky = (packed mantissa == 0) & (in_prod != 0); no shifted-out OR logic instantiated.

Structure
REQ-031 Shared package fmadd_pkg: EXP_W/MAN_W/BIAS defaults, P and LZC-width derivation functions, signed exponent-width constant.
REQ-032 One sub-module fmadd_lzc (parametrised leading-zero counter, combinational, width P, output 0..P), instantiated in S1.

Verification (defaults, P=16)
REQ-033 prod=16'h4000, exp_db=254, out_ready=1 -> after 2 cycles exp=127, man=16'h8000, sticky=0, ovf=0.
REQ-034 prod=16'h8000, exp_db=254 -> exp=128, man=16'h8000; prod=16'h8000, exp_db=382 -> exp=256, ovf=1.
REQ-035 prod=16'h4001, exp_db=120 -> E=-7, shift 8, man=16'h0080, exp=0, sticky=1 with macro, 0 without; exp_db=100 -> man=0, sticky=1 in both builds.
REQ-036 out_ready low for 4 cycles while driving 4 products back-to-back -> in_ready falls after 2 accepted, all 4 emerge in order, none lost.
REQ-037 prod=0, exp_db=300 -> out_no = {sign,0,0}, sticky=0; rst_l pulsed low with both stages full -> out_valid=0 next edge, no stale result after release.

Source files
------------

// File: rtl/fmadd_pkg.sv
// Shared sizing for the product normalizer: format defaults and width derivations
// used by the pipeline, its interface and the leading-zero counter.
package fmadd_pkg;
  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 7;
  localparam int BIAS_DEF  = 127;

  function automatic int prod_w(input int man_w);
    return 2 * man_w + 2;
  endfunction

  function automatic int lzc_w(input int p);
    return $clog2(p + 1);
  endfunction

  // Signed exponent width: two guard bits above the double-biased sum plus sign.
  function automatic int sexp_w(input int exp_w);
    return exp_w + 3;
  endfunction

  localparam int SEXP_W_DEF = sexp_w(EXP_W_DEF);
endpackage

// File: rtl/fmadd_mul_pn_pipe_if.sv
// Valid/ready handshake bundle for the product normalizer: product in, packed result out.
interface fmadd_mul_pn_pipe_if
  import fmadd_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
);
  localparam int P = prod_w(MAN_W);

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sign;
  logic [EXP_W:0]       in_exp_db;
  logic [P-1:0]         in_prod;
  logic                 out_valid;
  logic                 out_ready;
  logic [EXP_W+P+1:0]   out_no;
  logic                 out_sticky;
  logic                 out_ovf;

  modport master (
    output in_valid, in_sign, in_exp_db, in_prod, out_ready,
    input  in_ready, out_valid, out_no, out_sticky, out_ovf
  );

  modport slave (
    input  in_valid, in_sign, in_exp_db, in_prod, out_ready,
    output in_ready, out_valid, out_no, out_sticky, out_ovf
  );
endinterface

// File: rtl/fmadd_lzc.sv
// Combinational leading-zero counter; an all-zero input reports the full width P.
module fmadd_lzc
  import fmadd_pkg::*;
#(
  parameter int P    = prod_w(MAN_W_DEF),
  parameter int LZ_W = lzc_w(P)
) (
  input  logic [P-1:0]    i_data,
  output logic [LZ_W-1:0] o_cnt
);
  logic w_found;

  always_comb begin
    o_cnt   = LZ_W'(P);
    w_found = 1'b0;
    for (int i = P - 1; i >= 0; i--) begin
      if (!w_found && i_data[i]) begin
        o_cnt   = LZ_W'(P - 1 - i);
        w_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fmadd_mul_pn_pipe.sv
// Two-stage normalizer for raw multiplier products (S1: LZC + exponent, S2: shift + pack).
// Define FMADD_PN_PIPE_EXACT_STICKY_EN to make out_sticky the OR of all denormal shift-out bits.
module fmadd_mul_pn_pipe
  import fmadd_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int BIAS  = BIAS_DEF
) (
  input  logic               clk,
  input  logic               rst_l,
  fmadd_mul_pn_pipe_if.slave bus
);
  localparam int P    = prod_w(MAN_W);
  localparam int LZ_W = lzc_w(P);
  localparam int EW   = sexp_w(EXP_W);

  function automatic logic [P-1:0] denorm_shift(input logic [P-1:0] norm,
                                                input logic signed [EW-1:0] e);
    int sh;
    sh = 1 - int'(e);
    if (sh > P) sh = P;
    return norm >> sh;
  endfunction

`ifdef FMADD_PN_PIPE_EXACT_STICKY_EN
  function automatic logic lost_bits(input logic [P-1:0] norm,
                                     input logic signed [EW-1:0] e);
    int           sh;
    logic [P-1:0] mask;
    sh = 1 - int'(e);
    if (sh > P) sh = P;
    mask = (sh >= P) ? '1 : ((P'(1) << sh) - P'(1));
    return |(norm & mask);
  endfunction
`endif

  logic                 w_s1_adv;
  logic                 w_in_fire;
  logic                 w_s2_load;
  logic [LZ_W-1:0]      w_lz_p0;
  logic signed [EW-1:0] w_e_p0;

  logic                 r_vld_p1;
  logic                 r_sign_p1;
  logic [P-1:0]         r_prod_p1;
  logic [LZ_W-1:0]      r_lz_p1;
  logic signed [EW-1:0] r_e_p1;

  logic [P-1:0]         w_norm_p1;
  logic [P-1:0]         w_man_p1;
  logic [EXP_W:0]       w_exp_p1;
  logic                 w_zero_p1;
  logic                 w_denorm_p1;
  logic                 w_ovf_p1;
  logic                 w_sticky_p1;

  logic                 r_vld_p2;
  logic [EXP_W+P+1:0]   r_no_p2;
  logic                 r_sticky_p2;
  logic                 r_ovf_p2;

  assign w_s1_adv     = !r_vld_p2 || bus.out_ready;
  assign bus.in_ready = !r_vld_p1 || w_s1_adv;
  assign w_in_fire    = bus.in_valid && bus.in_ready;
  assign w_s2_load    = r_vld_p1 && w_s1_adv;

  // ---- stage 0 -> S1: leading-zero count and unbiased exponent
  fmadd_lzc #(.P(P), .LZ_W(LZ_W)) u_lzc (
    .i_data (bus.in_prod),
    .o_cnt  (w_lz_p0)
  );

  assign w_e_p0 = $signed({2'b00, bus.in_exp_db}) - $signed(EW'(BIAS)) + $signed(EW'(1))
                - $signed({{(EW - LZ_W){1'b0}}, w_lz_p0});

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_vld_p1  <= 1'b0;
      r_sign_p1 <= 1'b0;
      r_prod_p1 <= '0;
      r_lz_p1   <= '0;
      r_e_p1    <= '0;
    end else begin
      if (bus.in_ready) r_vld_p1 <= bus.in_valid;
      if (w_in_fire) begin
        r_sign_p1 <= bus.in_sign;
        r_prod_p1 <= bus.in_prod;
        r_lz_p1   <= w_lz_p0;
        r_e_p1    <= w_e_p0;
      end
    end
  end

  // ---- S1 -> S2: normalize, denormalize when E <= 0, pack
  assign w_norm_p1   = r_prod_p1 << r_lz_p1;
  assign w_zero_p1   = (r_prod_p1 == '0);
  assign w_denorm_p1 = (r_e_p1 < $signed(EW'(1)));
  assign w_ovf_p1    = !w_zero_p1 && (r_e_p1 >= $signed(EW'((1 << EXP_W) - 1)));

  always_comb begin
    w_man_p1 = w_norm_p1;
    w_exp_p1 = r_e_p1[EXP_W:0];
    if (w_zero_p1) begin
      w_man_p1 = '0;
      w_exp_p1 = '0;
    end else if (w_denorm_p1) begin
      w_man_p1 = denorm_shift(w_norm_p1, r_e_p1);
      w_exp_p1 = '0;
    end
  end

`ifdef FMADD_PN_PIPE_EXACT_STICKY_EN
  assign w_sticky_p1 = !w_zero_p1 && w_denorm_p1 && lost_bits(w_norm_p1, r_e_p1);
`else
  assign w_sticky_p1 = !w_zero_p1 && (w_man_p1 == '0);
`endif

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_vld_p2    <= 1'b0;
      r_no_p2     <= '0;
      r_sticky_p2 <= 1'b0;
      r_ovf_p2    <= 1'b0;
    end else begin
      if (w_s1_adv) r_vld_p2 <= r_vld_p1;
      if (w_s2_load) begin
        r_no_p2     <= {r_sign_p1, w_exp_p1, w_man_p1};
        r_sticky_p2 <= w_sticky_p1;
        r_ovf_p2    <= w_ovf_p1;
      end
    end
  end

  assign bus.out_valid  = r_vld_p2;
  assign bus.out_no     = r_no_p2;
  assign bus.out_sticky = r_sticky_p2;
  assign bus.out_ovf    = r_ovf_p2;
endmodule

// File: tb/tb_fmadd_mul_pn_pipe.sv
// Directed + randomized bench for fmadd_mul_pn_pipe with an arithmetic reference model.
module tb_fmadd_mul_pn_pipe;
  typedef struct {
    logic [25:0] no;
    logic        sticky;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_l;
  always #5 clk = ~clk;

  fmadd_mul_pn_pipe_if #(.EXP_W(8), .MAN_W(7)) bif ();

  fmadd_mul_pn_pipe #(.EXP_W(8), .MAN_W(7), .BIAS(127)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bif)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_out   = 0;
  exp_t        q[$];
  logic        in_acc;
  logic        rand_ready = 1'b0;
  logic [25:0] last_no;
  logic        last_sticky;
  logic        last_ovf;

`ifdef FMADD_PN_PIPE_EXACT_STICKY_EN
  localparam logic EXACT = 1'b1;
`else
  localparam logic EXACT = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Reference: scale the product up until its top bit is set, then denormalize by division.
  function automatic exp_t model(input logic s, input logic [8:0] edb, input logic [15:0] prod);
    exp_t   r;
    int     e;
    longint m;
    longint div;
    int     sh;
    r.no = {s, 25'd0};
    r.sticky = 1'b0;
    r.ovf = 1'b0;
    if (prod != 16'd0) begin
      m = longint'(prod);
      e = int'(edb) - 127 + 1;
      while (m < 32768) begin
        m = m * 2;
        e = e - 1;
      end
      r.ovf = (e >= 255);
      if (e >= 1) begin
        r.no = {s, 9'(e), 16'(m)};
      end else begin
        sh = 1 - e;
        if (sh > 16) sh = 16;
        div = longint'(1) << sh;
        r.no = {s, 9'd0, 16'(m / div)};
        r.sticky = EXACT ? ((m % div) != 0) : ((m / div) == 0);
      end
    end
    return r;
  endfunction

  task automatic tick();
    exp_t ex;
    @(negedge clk);
    if (bif.out_valid && bif.out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 32'(bif.out_valid), 32'd0);
      end else begin
        ex = q.pop_front();
        chk("out_no", 32'(bif.out_no), 32'(ex.no));
        chk("out_sticky", 32'(bif.out_sticky), 32'(ex.sticky));
        chk("out_ovf", 32'(bif.out_ovf), 32'(ex.ovf));
      end
      last_no = bif.out_no;
      last_sticky = bif.out_sticky;
      last_ovf = bif.out_ovf;
      n_out++;
    end
    if (bif.in_valid && bif.in_ready) begin
      q.push_back(model(bif.in_sign, bif.in_exp_db, bif.in_prod));
      in_acc = 1'b1;
    end
    @(posedge clk);
    #1;
    if (rand_ready) bif.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic s, input logic [8:0] e, input logic [15:0] p);
    int n = 0;
    bif.in_valid = 1'b1;
    bif.in_sign = s;
    bif.in_exp_db = e;
    bif.in_prod = p;
    in_acc = 1'b0;
    while (!in_acc && n < 60) begin
      tick();
      n++;
    end
    chk("send_accept", 32'(in_acc), 32'd1);
    bif.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic dir(input string tag, input logic s, input logic [8:0] e, input logic [15:0] p,
                     input logic [25:0] w_no, input logic w_st, input logic w_ovf);
    send(s, e, p);
    drain();
    chk({tag, "_no"}, 32'(last_no), 32'(w_no));
    chk({tag, "_sticky"}, 32'(last_sticky), 32'(w_st));
    chk({tag, "_ovf"}, 32'(last_ovf), 32'(w_ovf));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25:0] snap;
    logic [15:0] p;
    int          n0;

    rst_l = 1'b0;
    bif.in_valid = 1'b0;
    bif.in_sign = 1'b0;
    bif.in_exp_db = '0;
    bif.in_prod = '0;
    bif.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bif.in_ready), 32'd1);
    chk("rst_out_no", 32'(bif.out_no), 32'd0);
    chk("rst_sticky", 32'(bif.out_sticky), 32'd0);
    chk("rst_ovf", 32'(bif.out_ovf), 32'd0);
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;

    // Latency: result appears on the second edge after presentation.
    send(1'b0, 9'd254, 16'h4000);
    chk("lat_s1_empty_out", 32'(bif.out_valid), 32'd0);
    tick();
    chk("lat_s2_out_valid", 32'(bif.out_valid), 32'd1);
    tick();
    chk("lat_no", 32'(last_no), 32'({1'b0, 9'd127, 16'h8000}));
    chk("lat_sticky", 32'(last_sticky), 32'd0);
    chk("lat_ovf", 32'(last_ovf), 32'd0);

    dir("norm128", 1'b1, 9'd254, 16'h8000, {1'b1, 9'd128, 16'h8000}, 1'b0, 1'b0);
    dir("ovf256", 1'b0, 9'd382, 16'h8000, {1'b0, 9'd256, 16'h8000}, 1'b0, 1'b1);
    dir("denorm8", 1'b0, 9'd120, 16'h4001, {1'b0, 9'd0, 16'h0080}, EXACT, 1'b0);
    dir("denorm_all", 1'b1, 9'd100, 16'h4001, {1'b1, 9'd0, 16'h0000}, 1'b1, 1'b0);
    dir("zero_prod", 1'b1, 9'd300, 16'h0000, {1'b1, 9'd0, 16'h0000}, 1'b0, 1'b0);

    // Backpressure: two accepted, then stall with stable output, then release.
    n0 = n_out;
    bif.out_ready = 1'b0;
    send(1'b0, 9'd200, 16'h1234);
    send(1'b1, 9'd130, 16'h00F0);
    chk("bp_in_ready_low", 32'(bif.in_ready), 32'd0);
    bif.in_valid = 1'b1;
    bif.in_sign = 1'b0;
    bif.in_exp_db = 9'd127;
    bif.in_prod = 16'h0001;
    tick();
    snap = bif.out_no;
    tick();
    chk("bp_hold_no", 32'(bif.out_no), 32'(snap));
    chk("bp_hold_valid", 32'(bif.out_valid), 32'd1);
    chk("bp_in_ready_still_low", 32'(bif.in_ready), 32'd0);
    bif.out_ready = 1'b1;
    send(1'b0, 9'd127, 16'h0001);
    send(1'b1, 9'd140, 16'hFFFF);
    drain();
    chk("bp_count", 32'(n_out - n0), 32'd4);

    // Reset with both stages full discards everything.
    bif.out_ready = 1'b0;
    send(1'b0, 9'd150, 16'h2222);
    send(1'b1, 9'd160, 16'h3333);
    chk("mid_full_valid", 32'(bif.out_valid), 32'd1);
    rst_l = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bif.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bif.in_ready), 32'd1);
    chk("mid_rst_no", 32'(bif.out_no), 32'd0);
    q.delete();
    @(negedge clk);
    rst_l = 1'b1;
    bif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_no_out", 32'(bif.out_valid), 32'd0);
    end

    // Randomized traffic with random downstream stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      p = 16'($urandom) >> $urandom_range(0, 16);
      if ($urandom_range(0, 15) == 0) p = 16'h0000;
      send(1'($urandom), 9'($urandom_range(0, 511)), p);
    end
    rand_ready = 1'b0;
    bif.out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
